// File: rtl/pinball_video_pkg.sv
// Shared video constants and helpers for the pinball display pipeline.
package pinball_video_pkg;

    localparam int RGB_W_DEF = 8;
    localparam logic [RGB_W_DEF-1:0] TRANSPARENT_DEF = 8'hFF;
    localparam int MAX_LAYERS = 16;

    typedef logic [3:0] layer_idx_t;

    // True when two or more bits are set: clearing the lowest set bit leaves something behind.
    function automatic logic multi_hot(input logic [MAX_LAYERS-1:0] v);
        return (v & (v - 16'd1)) != 16'd0;
    endfunction

endpackage

// File: rtl/layered_rgb_mux_if.sv
// Pixel bus between a layer source (master) and the layered RGB mixer (slave).
interface layered_rgb_mux_if
    import pinball_video_pkg::*;
#(
    parameter int NUM_LAYERS = 4,
    parameter int RGB_W      = RGB_W_DEF,
    parameter int CNT_W      = 16
);
    logic [NUM_LAYERS-1:0]       draw;
    logic [NUM_LAYERS*RGB_W-1:0] rgb_layers;
    logic [RGB_W-1:0]            rgb_bg;
    logic [NUM_LAYERS-1:0]       layer_en;
    logic                        start_of_frame;
    logic [RGB_W-1:0]            rgb_out;
    logic [NUM_LAYERS-1:0]       coll_flags;
    logic [CNT_W-1:0]            coll_count;
    logic                        frame_done;

    modport master (
        output draw, rgb_layers, rgb_bg, layer_en, start_of_frame,
        input  rgb_out, coll_flags, coll_count, frame_done
    );

    modport slave (
        input  draw, rgb_layers, rgb_bg, layer_en, start_of_frame,
        output rgb_out, coll_flags, coll_count, frame_done
    );
endinterface

// File: rtl/rgb_priority_sel.sv
// Combinational priority picker: the lowest-index active layer wins.
module rgb_priority_sel
    import pinball_video_pkg::*;
#(
    parameter int NUM_LAYERS = 4,
    parameter int RGB_W      = RGB_W_DEF
) (
    input  logic [NUM_LAYERS-1:0]       active_i,
    input  logic [NUM_LAYERS*RGB_W-1:0] rgb_layers_i,
    output logic [RGB_W-1:0]            rgb_sel_o,
    output logic                        valid_o
);
    layer_idx_t sel_idx_s;

    // Walk from the lowest priority upward so the last hit is the winner.
    always_comb begin
        sel_idx_s = 4'd0;
        for (int i = NUM_LAYERS - 1; i >= 0; i--) begin
            sel_idx_s = active_i[i] ? layer_idx_t'(i) : sel_idx_s;
        end
    end

    assign valid_o   = |active_i;
    assign rgb_sel_o = rgb_layers_i[int'(sel_idx_s) * RGB_W +: RGB_W];
endmodule

// File: rtl/layered_rgb_mux.sv
// Layered RGB mixer: priority overlay of foreground layers on a background, with
// optional per-frame collision statistics compiled in by LAYERED_MUX_COLLISION_EN.
module layered_rgb_mux
    import pinball_video_pkg::*;
#(
    parameter int               NUM_LAYERS  = 4,
    parameter int               RGB_W       = RGB_W_DEF,
    parameter logic [RGB_W-1:0] TRANSPARENT = RGB_W'(TRANSPARENT_DEF),
    parameter int               CNT_W       = 16
) (
    input logic               clk,
    input logic               resetN,
    layered_rgb_mux_if.slave  bus
);
    logic [NUM_LAYERS-1:0] active_s;
    logic [RGB_W-1:0]      rgb_sel_s;
    logic                  sel_valid_s;
    logic [RGB_W-1:0]      rgb_d;
    logic [RGB_W-1:0]      rgb_q;

    // A layer only counts when requested, enabled and not keyed out.
    always_comb begin
        active_s = '0;
        for (int i = 0; i < NUM_LAYERS; i++) begin
            active_s[i] = bus.draw[i] & bus.layer_en[i] &
                          (bus.rgb_layers[i*RGB_W +: RGB_W] != TRANSPARENT);
        end
    end

    rgb_priority_sel #(
        .NUM_LAYERS (NUM_LAYERS),
        .RGB_W      (RGB_W)
    ) u_sel (
        .active_i     (active_s),
        .rgb_layers_i (bus.rgb_layers),
        .rgb_sel_o    (rgb_sel_s),
        .valid_o      (sel_valid_s)
    );

    assign rgb_d = sel_valid_s ? rgb_sel_s : bus.rgb_bg;

    // Output pixel register.
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            rgb_q <= '0;
        end else begin
            rgb_q <= rgb_d;
        end
    end

    assign bus.rgb_out = rgb_q;

`ifdef LAYERED_MUX_COLLISION_EN
    logic                  coll_s;
    logic [NUM_LAYERS-1:0] pix_flags_s;
    logic [NUM_LAYERS-1:0] acc_flags_d, acc_flags_q;
    logic [CNT_W-1:0]      acc_cnt_d, acc_cnt_q;
    logic [NUM_LAYERS-1:0] coll_flags_d, coll_flags_q;
    logic [CNT_W-1:0]      coll_cnt_d, coll_cnt_q;
    logic                  frame_done_d, frame_done_q;

    // The start-of-frame pixel seeds the fresh accumulator instead of closing the old frame.
    always_comb begin
        coll_s       = multi_hot(MAX_LAYERS'(active_s));
        pix_flags_s  = coll_s ? active_s : '0;
        coll_flags_d = coll_flags_q;
        coll_cnt_d   = coll_cnt_q;
        frame_done_d = bus.start_of_frame;
        if (bus.start_of_frame) begin
            coll_flags_d = acc_flags_q;
            coll_cnt_d   = acc_cnt_q;
            acc_flags_d  = pix_flags_s;
            acc_cnt_d    = coll_s ? CNT_W'(1'b1) : '0;
        end else begin
            acc_flags_d  = acc_flags_q | pix_flags_s;
            acc_cnt_d    = (coll_s && (acc_cnt_q != '1)) ? acc_cnt_q + CNT_W'(1'b1) : acc_cnt_q;
        end
    end

    // Accumulators and last-frame snapshot.
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            acc_flags_q  <= '0;
            acc_cnt_q    <= '0;
            coll_flags_q <= '0;
            coll_cnt_q   <= '0;
            frame_done_q <= 1'b0;
        end else begin
            acc_flags_q  <= acc_flags_d;
            acc_cnt_q    <= acc_cnt_d;
            coll_flags_q <= coll_flags_d;
            coll_cnt_q   <= coll_cnt_d;
            frame_done_q <= frame_done_d;
        end
    end

    assign bus.coll_flags = coll_flags_q;
    assign bus.coll_count = coll_cnt_q;
    assign bus.frame_done = frame_done_q;
`else
    assign bus.coll_flags = '0;
    assign bus.coll_count = '0;
    assign bus.frame_done = 1'b0;
`endif

endmodule

// File: doc/layered_rgb_mux.md
LAYERED_RGB_MUX -- requirements
Module: layered_rgb_mux

Interface
REQ-001 SHALL have parameter NUM_LAYERS, default 4, number of foreground layers (2..16); layer 0 is highest priority.
REQ-002 SHALL have parameter RGB_W, default 8, pixel colour width.
REQ-003 SHALL have parameter TRANSPARENT, default 8'hFF (RGB_W bits), colour key treated as "not drawn".
REQ-004 SHALL have parameter CNT_W, default 16, collision pixel counter width.
REQ-005 clk  input  1  system clock, all logic on rising edge.
REQ-006 resetN  input  1  reset, asynchronous, active-low.
REQ-007 draw  input  NUM_LAYERS  per-layer draw request for current pixel.
REQ-008 rgb_layers  input  NUM_LAYERS*RGB_W  packed layer colours; layer i at bits [i*RGB_W +: RGB_W].
REQ-009 rgb_bg  input  RGB_W  background colour.
REQ-010 layer_en  input  NUM_LAYERS  static per-layer enable; disabled layer ignored everywhere.
REQ-011 start_of_frame  input  1  one-cycle pulse on first pixel of a frame.
REQ-012 rgb_out  output  RGB_W  registered mixed pixel.
REQ-013 coll_flags  output  NUM_LAYERS  per-layer collision flags of last completed frame.
REQ-014 coll_count  output  CNT_W  collision pixel count of last completed frame.
REQ-015 frame_done  output  1  one-cycle pulse when coll_flags/coll_count update.

Function
REQ-016 Layer i SHALL be "active" when draw[i] & layer_en[i] & (pixel_i != TRANSPARENT).
REQ-017 rgb_out SHALL equal, one cycle after sampling, the colour of the lowest-index active layer, else rgb_bg.
REQ-018 A pixel SHALL be a collision when two or more layers are active in the same cycle.
REQ-019 On a collision, accumulator bit i SHALL be set for every active layer i, and the pixel accumulator SHALL increment by 1.
REQ-020 The pixel accumulator SHALL saturate at 2^CNT_W-1, never wrap.
REQ-021 On start_of_frame, coll_flags and coll_count SHALL load the accumulators (excluding the current pixel), and frame_done SHALL pulse high the following cycle for exactly one cycle.
REQ-022 The pixel sampled with start_of_frame SHALL count into the new, cleared accumulator (accumulator = that pixel's contribution only).
REQ-023 coll_flags/coll_count SHALL hold between frame_done pulses.
REQ-024 Back-to-back start_of_frame pulses SHALL each produce a snapshot and a frame_done pulse.
REQ-025 Changing layer_en mid-frame SHALL take effect on the next sampled pixel.

Reset
REQ-026 On resetN low: rgb_out=0, coll_flags=0, coll_count=0, frame_done=0, accumulators=0, immediately and asynchronously.
REQ-027 After reset release, the first frame_done SHALL occur only after the first start_of_frame.

Configuration
REQ-028 With macro LAYERED_MUX_COLLISION_EN defined, collision detection/accumulation (REQ-018..REQ-025) SHALL be compiled in.
REQ-029 Without LAYERED_MUX_COLLISION_EN, coll_flags, coll_count and frame_done SHALL be tied to 0 and no collision registers SHALL exist; rgb_out behaviour is unchanged.

Structure
REQ-030 Package pinball_video_pkg SHALL hold the default RGB_W, TRANSPARENT colour constant, and a layer-index typedef.
REQ-031 Priority select SHALL be a sub-module rgb_priority_sel (combinational: active vector + colours -> selected colour, valid).

Verification
REQ-032 draw=4'b0000 -> rgb_out=rgb_bg one cycle later; no collision counted.
REQ-033 draw=4'b0110, layer1=8'h1C, layer2=8'hE0 -> rgb_out=8'h1C; next start_of_frame gives coll_flags=4'b0110, coll_count=1, frame_done pulse.
REQ-034 draw=4'b0011, layer0=8'hFF (transparent), layer1=8'h03 -> rgb_out=8'h03; no collision.
REQ-035 layer_en=4'b1110, draw=4'b0011 -> rgb_out=layer1 colour; no collision.
REQ-036 CNT_W=4, 20 collision pixels in one frame -> coll_count=15 at frame_done.
REQ-037 Collision present on start_of_frame cycle -> snapshot excludes it; following frame reports count>=1; resetN pulse mid-frame -> all outputs 0, no frame_done until next start_of_frame.
